cache_pwb: RTL and testbench
============================

Name: cache_pwb

Overview:
- Parametrised write-back, set-associative cache; next generation of the fixed 1MB/4-way/32B-line cache.
- Sits between the PE/TB word port and main memory (MM) line port.
- Generalises way count, set count and line length; replaces 3-bit LRU with tree pseudo-LRU.
- Adds per-line flush/invalidate and a whole-cache flush_all walk.

Parameters:
IDX_BITS, 6, set index width; SETS = 2**IDX_BITS
WAYS, 4, associativity; legal values 2, 4, 8
LINE_WORDS, 8, 32-bit words per line; legal values 4, 8, 16
OFF_BITS, log2(LINE_WORDS), word offset width (derived, not overridden)
TAG_BITS, 30-IDX_BITS-OFF_BITS, tag width (derived)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
a  in  32  PE byte address; tag a[31:32-TAG_BITS], index a[2+OFF_BITS+IDX_BITS-1:2+OFF_BITS], offset a[2+OFF_BITS-1:2]
be  in  4  byte enables for write
read  in  1  read request
write  in  1  write request
flush  in  1  write back the line at a if dirty; keep it valid
invalidate  in  1  with flush: write back if dirty, then clear valid. Alone: clear valid with no write-back
flush_all  in  1  write back every dirty line and invalidate all
wd  in  32  write data
rd  out  32  read data; 0 when rd_valid low
rd_valid  out  1  one-cycle read-data strobe
ready  out  1  cache can accept a request this cycle
mm_a  out  32  line-aligned MM address (low 2+OFF_BITS bits zero)
mm_read  out  1  MM line-read command
mm_write  out  1  MM line-write command
mm_writedata  out  32*LINE_WORDS  eviction/flush data
mm_readdata  in  32*LINE_WORDS  fill data
mm_readdata_valid  in  1  fill data valid, one cycle
mm_ready  in  1  MM accepts the command asserted this cycle

Behaviour:
- Reset (reset=0, async): FSM to IDLE; all valid, dirty and PLRU bits cleared. Outputs go to ready=0, rd_valid=0, mm_read=0, mm_write=0, mm_a=0, rd=0. Tag and data arrays are not reset.
- First cycle after reset release: ready=1.
- Reset mid-operation aborts any in-flight MM command immediately. Late mm_readdata_valid after release is ignored.
- Request acceptance: a request is accepted on an edge where ready=1 and any command is high. Inputs are registered at acceptance; ready drops the next cycle unless the request is a hit.
- Command priority: flush_all > flush/invalidate > write > read. Lower-priority commands in the same cycle are dropped.
- FSM states: IDLE, LOOKUP, WB (write-back), FILL_REQ, FILL_WAIT, WALK.
- Read hit:
  - LOOKUP is the cycle after acceptance.
  - rd_valid=1 and rd = selected word in that cycle; ready=1 in the same cycle (back-to-back hits at 1 request/cycle).
  - PLRU updates toward the hit way.
- Write hit:
  - Bytes merged per be into the hit way in LOOKUP; dirty set; PLRU updated.
  - No rd_valid; ready=1 in LOOKUP.
- Miss, victim selection: lowest-index invalid way; else the tree-PLRU victim.
  - Victim valid and dirty: WB, then FILL_REQ.
  - Otherwise: FILL_REQ directly.
- WB: mm_write=1, mm_a = {victim tag, index, 0}, mm_writedata = victim line. All held stable until the cycle mm_ready=1, which completes the write.
- FILL_REQ: mm_read=1, mm_a = {req tag, index, 0}, held until mm_ready=1, then FILL_WAIT.
- FILL_WAIT: on mm_readdata_valid, the line is written to the victim way.
  - Write miss: the PE word is merged per be and dirty=1.
  - Read miss: dirty=0 and rd_valid=1 the next cycle with the requested word.
  - In both cases valid=1, tag written, PLRU updated, then IDLE with ready=1.
- mm_read and mm_write are never asserted together.
- flush/invalidate:
  - Miss: no-op, ready back next cycle.
  - Hit and dirty with flush: WB of that line, then dirty=0. Valid is cleared only if invalidate=1.
  - PLRU is not updated by flush/invalidate.
- WALK (flush_all):
  - 0-based set and way counters cover SETS*WAYS slots, set-major, way-minor, one slot per cycle.
  - A dirty valid slot enters WB, then resumes at the next slot.
  - Every slot ends valid=0, dirty=0.
  - Final slot = SETS-1, way WAYS-1; the counters do not wrap. Then IDLE, ready=1.
  - New requests are ignored while ready=0.
- Requests while ready=0 are ignored; the PE must hold them.

Test Plan:
- Reset held 3 cycles with mm_ready=1 -> ready=0, mm_read=0, mm_write=0 during reset; ready=1 the first cycle after release.
- Read 0x00001000, cold, with mm_readdata word0=0xDEADBEEF -> mm_read with mm_a=0x00001000, no mm_write. rd_valid with rd=0xDEADBEEF the cycle after mm_readdata_valid. Re-read -> hit, rd_valid in the LOOKUP cycle.
- Write 0x00001004 be=4'b0011 wd=0x1234ABCD on a line holding 0xFFFFFFFF -> read-back gives 0xFFFFABCD; line dirty.
- Fill WAYS+1 distinct tags into set 0 after dirtying the first -> exactly one mm_write, mm_a = first line, data matches; victim matches PLRU model.
- flush (no invalidate) on the dirty line -> one mm_write; repeat flush -> no mm_write; a read then hits.
- Dirty 3 lines in different sets, then flush_all with mm_ready stalling 5 cycles per command -> exactly 3 mm_writes, ready low for SETS*WAYS+ cycles; every subsequent read misses.

Source files
------------

// File: rtl/cache_pwb.sv
// rtl/cache_pwb.sv - parametrised write-back set-associative cache with tree PLRU and flush walk
module cache_pwb #(
   parameter int IDX_BITS   = 6,
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                a,
   input  logic [3:0]                 be,
   input  logic                       read,
   input  logic                       write,
   input  logic                       flush,
   input  logic                       invalidate,
   input  logic                       flush_all,
   input  logic [31:0]                wd,
   output logic [31:0]                rd,
   output logic                       rd_valid,
   output logic                       ready,
   output logic [31:0]                mm_a,
   output logic                       mm_read,
   output logic                       mm_write,
   output logic [32*LINE_WORDS-1:0]   mm_writedata,
   input  logic [32*LINE_WORDS-1:0]   mm_readdata,
   input  logic                       mm_readdata_valid,
   input  logic                       mm_ready
);

   localparam int OFF_BITS  = $clog2(LINE_WORDS);
   localparam int TAG_BITS  = 30 - IDX_BITS - OFF_BITS;
   localparam int WAY_BITS  = $clog2(WAYS);
   localparam int SLOT_BITS = IDX_BITS + WAY_BITS;
   localparam int SLOTS     = 2**SLOT_BITS;
   localparam int LINE_BITS = 32*LINE_WORDS;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, WALK} state_t;
   typedef enum logic [1:0] {WB_MISS, WB_FLUSH, WB_WALK} wb_kind_t;

   state_t state, state_nx;
   wb_kind_t wb_kind;

   // Line state; valid/dirty/PLRU are reset, tag and data arrays are not.
   logic [SLOTS-1:0]     valid_q, dirty_q;
   logic [WAYS-1:0]      plru_q [2**IDX_BITS];
   logic [TAG_BITS-1:0]  tag_mem [SLOTS];
   logic [LINE_BITS-1:0] data_mem [SLOTS];

   // Registered request
   logic [TAG_BITS-1:0] req_tag;
   logic [IDX_BITS-1:0] req_idx;
   logic [OFF_BITS-1:0] req_off;
   logic [3:0]          req_be;
   logic [31:0]         req_wd;
   logic                req_rd, req_wr, req_fl, req_inv;

   logic [SLOT_BITS-1:0] sel_slot, walk_slot;
   logic [31:0]          rd_q;
   logic                 rdv_q;

   logic                 hit, inv_any, victim_dirty, hit_dirty, accept, walk_last, slot_dirty;
   logic [WAY_BITS-1:0]  hit_way, inv_way, victim_way;
   logic [LINE_BITS-1:0] hit_line;
   logic [31:0]          hit_word;
   logic                 unused_addr;

   assign unused_addr = ^a[1:0];

   // Tree PLRU: each node bit points toward the less recently used half.
   function automatic logic [WAY_BITS-1:0] plru_pick(input logic [WAYS-1:0] bits);
      logic [WAY_BITS-1:0] node, way;
      node = '0;
      way  = '0;
      for (int l = 0; l < WAY_BITS; l++) begin
         way[WAY_BITS-1-l] = bits[node];
         node = WAY_BITS'(2*int'(node) + 1 + int'(bits[node]));
      end
      return way;
   endfunction

   function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                  input logic [WAY_BITS-1:0] way);
      logic [WAYS-1:0]     nb;
      logic [WAY_BITS-1:0] node;
      logic                b;
      nb   = bits;
      node = '0;
      for (int l = 0; l < WAY_BITS; l++) begin
         b        = way[WAY_BITS-1-l];
         nb[node] = ~b;
         node     = WAY_BITS'(2*int'(node) + 1 + int'(b));
      end
      return nb;
   endfunction

   function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [OFF_BITS-1:0] off,
                                                       input logic [3:0] bmask,
                                                       input logic [31:0] word);
      logic [LINE_BITS-1:0] res;
      res = line;
      for (int k = 0; k < LINE_WORDS*4; k++) begin
         if (OFF_BITS'(k/4) == off && bmask[k%4])
            res[k*8 +: 8] = word[(k%4)*8 +: 8];
      end
      return res;
   endfunction

   // Tag compare, lowest invalid way and victim choice for the registered set
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (valid_q[{req_idx, WAY_BITS'(w)}] && tag_mem[{req_idx, WAY_BITS'(w)}] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
         if (!valid_q[{req_idx, WAY_BITS'(w)}]) begin
            inv_any = 1'b1;
            inv_way = WAY_BITS'(w);
         end
      end
      victim_way   = inv_any ? inv_way : plru_pick(plru_q[req_idx]);
      victim_dirty = valid_q[{req_idx, victim_way}] && dirty_q[{req_idx, victim_way}];
      hit_dirty    = dirty_q[{req_idx, hit_way}];
      hit_line     = data_mem[{req_idx, hit_way}];
      hit_word     = hit_line[{req_off, 5'b0} +: 32];
   end

   assign accept     = ready && (read || write || flush || invalidate || flush_all);
   assign walk_last  = &walk_slot;
   assign slot_dirty = valid_q[walk_slot] && dirty_q[walk_slot];

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (accept) state_nx = flush_all ? WALK : LOOKUP;
         LOOKUP:
            if (req_rd || req_wr) begin
               if (hit) state_nx = accept ? (flush_all ? WALK : LOOKUP) : IDLE;
               else     state_nx = victim_dirty ? WB : FILL_REQ;
            end else begin
               state_nx = (hit && req_fl && hit_dirty) ? WB : IDLE;
            end
         WB:
            if (mm_ready) begin
               case (wb_kind)
                  WB_MISS:  state_nx = FILL_REQ;
                  WB_WALK:  state_nx = walk_last ? IDLE : WALK;
                  default:  state_nx = IDLE;
               endcase
            end
         FILL_REQ:
            if (mm_ready) state_nx = FILL_WAIT;
         FILL_WAIT:
            if (mm_readdata_valid) state_nx = IDLE;
         WALK:
            if (slot_dirty)     state_nx = WB;
            else if (walk_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Port outputs
   always_comb begin
      ready        = reset && (state == IDLE || (state == LOOKUP && (req_rd || req_wr) && hit));
      rd_valid     = 1'b0;
      rd           = 32'h0;
      mm_read      = 1'b0;
      mm_write     = 1'b0;
      mm_a         = 32'h0;
      mm_writedata = '0;
      if (state == LOOKUP && req_rd && hit) begin
         rd_valid = 1'b1;
         rd       = hit_word;
      end else if (state == IDLE && rdv_q) begin
         rd_valid = 1'b1;
         rd       = rd_q;
      end
      if (state == WB) begin
         mm_write     = 1'b1;
         mm_a         = {tag_mem[sel_slot], sel_slot[SLOT_BITS-1:WAY_BITS], {(2+OFF_BITS){1'b0}}};
         mm_writedata = data_mem[sel_slot];
      end else if (state == FILL_REQ) begin
         mm_read = 1'b1;
         mm_a    = {req_tag, req_idx, {(2+OFF_BITS){1'b0}}};
      end
   end

   // Request capture, line state, PLRU and walk bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         dirty_q   <= '0;
         for (int s = 0; s < 2**IDX_BITS; s++) plru_q[s] <= '0;
         req_tag   <= '0;
         req_idx   <= '0;
         req_off   <= '0;
         req_be    <= '0;
         req_wd    <= '0;
         req_rd    <= 1'b0;
         req_wr    <= 1'b0;
         req_fl    <= 1'b0;
         req_inv   <= 1'b0;
         sel_slot  <= '0;
         walk_slot <= '0;
         wb_kind   <= WB_MISS;
         rd_q      <= '0;
         rdv_q     <= 1'b0;
      end else begin
         rdv_q <= 1'b0;
         if (accept) begin
            req_tag   <= a[31 -: TAG_BITS];
            req_idx   <= a[2+OFF_BITS +: IDX_BITS];
            req_off   <= a[2 +: OFF_BITS];
            req_be    <= be;
            req_wd    <= wd;
            req_fl    <= !flush_all && flush;
            req_inv   <= !flush_all && invalidate;
            req_wr    <= !flush_all && !flush && !invalidate && write;
            req_rd    <= !flush_all && !flush && !invalidate && !write && read;
            walk_slot <= '0;
         end
         case (state)
            LOOKUP:
               if (req_rd || req_wr) begin
                  if (hit) begin
                     plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                     if (req_wr) dirty_q[{req_idx, hit_way}] <= 1'b1;
                  end else begin
                     sel_slot <= {req_idx, victim_way};
                     wb_kind  <= WB_MISS;
                  end
               end else if (hit) begin
                  if (req_fl && hit_dirty) begin
                     sel_slot <= {req_idx, hit_way};
                     wb_kind  <= WB_FLUSH;
                  end else if (req_inv) begin
                     valid_q[{req_idx, hit_way}] <= 1'b0;
                     dirty_q[{req_idx, hit_way}] <= 1'b0;
                  end
               end
            WB:
               if (mm_ready) begin
                  dirty_q[sel_slot] <= 1'b0;
                  if (wb_kind == WB_WALK || (wb_kind == WB_FLUSH && req_inv))
                     valid_q[sel_slot] <= 1'b0;
                  if (wb_kind == WB_WALK && !walk_last)
                     walk_slot <= walk_slot + 1'b1;
               end
            FILL_WAIT:
               if (mm_readdata_valid) begin
                  valid_q[sel_slot] <= 1'b1;
                  dirty_q[sel_slot] <= req_wr;
                  plru_q[req_idx]   <= plru_touch(plru_q[req_idx], sel_slot[WAY_BITS-1:0]);
                  if (req_rd) begin
                     rdv_q <= 1'b1;
                     rd_q  <= mm_readdata[{req_off, 5'b0} +: 32];
                  end
               end
            WALK:
               if (slot_dirty) begin
                  sel_slot <= walk_slot;
                  wb_kind  <= WB_WALK;
               end else begin
                  valid_q[walk_slot] <= 1'b0;
                  dirty_q[walk_slot] <= 1'b0;
                  if (!walk_last) walk_slot <= walk_slot + 1'b1;
               end
            default: ;
         endcase
      end
   end

   // Tag and data arrays: write-hit merge and line fill
   always_ff @(posedge clk) begin
      if (state == LOOKUP && req_wr && hit)
         data_mem[{req_idx, hit_way}] <= merge_word(hit_line, req_off, req_be, req_wd);
      if (state == FILL_WAIT && mm_readdata_valid) begin
         tag_mem[sel_slot]  <= req_tag;
         data_mem[sel_slot] <= req_wr ? merge_word(mm_readdata, req_off, req_be, req_wd) : mm_readdata;
      end
   end

endmodule

// File: tb/tb_cache_pwb.sv
// tb/tb_cache_pwb.sv - directed self-checking bench for cache_pwb
module tb_cache_pwb;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  a;
   logic [3:0]   be;
   logic         read, write, flush, invalidate, flush_all;
   logic [31:0]  wd;
   logic [31:0]  rd;
   logic         rd_valid, ready;
   logic [31:0]  mm_a;
   logic         mm_read, mm_write;
   logic [255:0] mm_writedata;
   logic [255:0] mm_readdata = '0;
   logic         mm_readdata_valid = 1'b0;
   logic         mm_ready = 1'b1;

   int npass = 0;
   int ntot  = 0;
   int stall = 0;
   int reads_acc = 0, writes_acc = 0, fills_done = 0;
   int cnt = 0, fdly = 0;
   logic [31:0]  fill_addr = '0, last_wa = '0;
   logic [255:0] last_wd = '0;
   logic         both_err = 1'b0;

   cache_pwb dut (
      .clk(clk), .reset(reset), .a(a), .be(be), .read(read), .write(write),
      .flush(flush), .invalidate(invalidate), .flush_all(flush_all), .wd(wd),
      .rd(rd), .rd_valid(rd_valid), .ready(ready), .mm_a(mm_a), .mm_read(mm_read),
      .mm_write(mm_write), .mm_writedata(mm_writedata), .mm_readdata(mm_readdata),
      .mm_readdata_valid(mm_readdata_valid), .mm_ready(mm_ready)
   );

   always #5 clk = ~clk;

   // Memory contents seen on fills: 0x1000 holds DEADBEEF then all-ones
   function automatic logic [255:0] line_data(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) begin
         if (la == 32'h0000_1000) l[i*32 +: 32] = (i == 0) ? 32'hDEADBEEF : 32'hFFFFFFFF;
         else                     l[i*32 +: 32] = {la[15:0], 8'hA5, 8'(i)};
      end
      return l;
   endfunction

   // Record commands the memory accepted
   always @(posedge clk) begin
      if (reset) begin
         if (mm_read && mm_write) both_err <= 1'b1;
         if (mm_read && mm_ready) begin
            reads_acc <= reads_acc + 1;
            fill_addr <= mm_a;
         end
         if (mm_write && mm_ready) begin
            writes_acc <= writes_acc + 1;
            last_wa    <= mm_a;
            last_wd    <= mm_writedata;
         end
      end
   end

   // Memory handshake: stall each command, return fill two cycles after acceptance
   always @(negedge clk) begin
      mm_readdata_valid = 1'b0;
      if (stall == 0) mm_ready = 1'b1;
      else if (mm_read || mm_write) begin
         if (cnt >= stall) begin mm_ready = 1'b1; cnt = 0; end
         else begin mm_ready = 1'b0; cnt++; end
      end else begin
         mm_ready = 1'b0;
         cnt = 0;
      end
      if (reads_acc != fills_done) begin
         if (fdly >= 1) begin
            mm_readdata_valid = 1'b1;
            mm_readdata = line_data(fill_addr);
            fills_done++;
            fdly = 0;
         end else fdly++;
      end
   end

   task automatic issue(input logic r, input logic w, input logic f, input logic inv, input logic fa,
                        input logic [31:0] addr, input logic [3:0] b, input logic [31:0] d,
                        output int lat, output logic [31:0] data);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      if (ready !== 1'b1) begin
         ntot++;
         $display("FAIL issue_ready_timeout addr %h: got ready=%b want 1", addr, ready);
      end
      a = addr; be = b; wd = d; read = r; write = w; flush = f; invalidate = inv; flush_all = fa;
      @(posedge clk);
      #1;
      read = 0; write = 0; flush = 0; invalidate = 0; flush_all = 0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(r ? (rd_valid === 1'b1) : (ready === 1'b1)) && lat < 2000);
      if (lat >= 2000) begin
         ntot++;
         $display("FAIL issue_done_timeout addr %h: got no completion want completion", addr);
      end
      data = rd;
   endtask

   task automatic test_reset();
      reset = 1'b0; a = 0; be = 0; wd = 0;
      read = 0; write = 0; flush = 0; invalidate = 0; flush_all = 0; stall = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ntot++; if (ready !== 1'b0) $display("FAIL reset_ready cyc %0d: got %b want 0", i, ready); else npass++;
         ntot++; if ({mm_read, mm_write} !== 2'b00) $display("FAIL reset_mm cyc %0d: got %b want 00", i, {mm_read, mm_write}); else npass++;
      end
      reset = 1'b1;
      @(negedge clk);
      ntot++; if (ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ready); else npass++;
      ntot++; if ({rd_valid, rd} !== 33'h0) $display("FAIL reset_rd: got %h want 0", {rd_valid, rd}); else npass++;
   endtask

   task automatic test_read_miss_hit();
      int lat, r0, w0; logic [31:0] d;
      r0 = reads_acc; w0 = writes_acc;
      issue(1, 0, 0, 0, 0, 32'h0000_1000, 4'h0, 32'h0, lat, d);
      ntot++; if (d !== 32'hDEADBEEF) $display("FAIL cold_read_data: got %h want deadbeef", d); else npass++;
      ntot++; if (lat <= 1) $display("FAIL cold_read_lat: got %0d want >1", lat); else npass++;
      ntot++; if (reads_acc - r0 !== 1) $display("FAIL cold_read_mmread: got %0d want 1", reads_acc - r0); else npass++;
      ntot++; if (fill_addr !== 32'h0000_1000) $display("FAIL cold_read_mma: got %h want 00001000", fill_addr); else npass++;
      ntot++; if (writes_acc !== w0) $display("FAIL cold_read_mmwrite: got %0d want %0d", writes_acc, w0); else npass++;
      r0 = reads_acc;
      issue(1, 0, 0, 0, 0, 32'h0000_1000, 4'h0, 32'h0, lat, d);
      ntot++; if (lat !== 1) $display("FAIL reread_lat: got %0d want 1", lat); else npass++;
      ntot++; if (d !== 32'hDEADBEEF) $display("FAIL reread_data: got %h want deadbeef", d); else npass++;
      ntot++; if (reads_acc !== r0) $display("FAIL reread_mmread: got %0d want %0d", reads_acc, r0); else npass++;
   endtask

   task automatic test_write_hit();
      int lat, r0; logic [31:0] d;
      r0 = reads_acc;
      issue(0, 1, 0, 0, 0, 32'h0000_1004, 4'b0011, 32'h1234ABCD, lat, d);
      ntot++; if (lat !== 1) $display("FAIL write_hit_ready: got %0d want 1", lat); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_1004, 4'h0, 32'h0, lat, d);
      ntot++; if (d !== 32'hFFFFABCD) $display("FAIL write_merge_data: got %h want ffffabcd", d); else npass++;
      ntot++; if (lat !== 1) $display("FAIL write_readback_lat: got %0d want 1", lat); else npass++;
      ntot++; if (reads_acc !== r0) $display("FAIL write_hit_mmread: got %0d want %0d", reads_acc, r0); else npass++;
   endtask

   task automatic test_evict();
      int lat, w0; logic [31:0] d;
      logic [31:0] fills [3];
      fills[0] = 32'h0000_1800; fills[1] = 32'h0000_2000; fills[2] = 32'h0000_2800;
      w0 = writes_acc;
      for (int i = 0; i < 3; i++) begin
         issue(1, 0, 0, 0, 0, fills[i], 4'h0, 32'h0, lat, d);
         ntot++; if (lat <= 1) $display("FAIL fill_way%0d_lat: got %0d want >1", i + 1, lat); else npass++;
      end
      ntot++; if (writes_acc !== w0) $display("FAIL fill_no_wb: got %0d want %0d", writes_acc, w0); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_3000, 4'h0, 32'h0, lat, d);
      ntot++; if (writes_acc - w0 !== 1) $display("FAIL evict_wb_count: got %0d want 1", writes_acc - w0); else npass++;
      ntot++; if (last_wa !== 32'h0000_1000) $display("FAIL evict_wb_addr: got %h want 00001000", last_wa); else npass++;
      ntot++; if (last_wd !== {{6{32'hFFFFFFFF}}, 32'hFFFFABCD, 32'hDEADBEEF})
         $display("FAIL evict_wb_data: got %h want ffff..ffffabcddeadbeef", last_wd); else npass++;
      ntot++; if (d !== 32'h3000A500) $display("FAIL evict_read_data: got %h want 3000a500", d); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_1800, 4'h0, 32'h0, lat, d);
      ntot++; if (lat !== 1) $display("FAIL plru_keep_1800: got lat %0d want 1", lat); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_3800, 4'h0, 32'h0, lat, d);
      ntot++; if (lat <= 1) $display("FAIL miss_3800: got lat %0d want >1", lat); else npass++;
      ntot++; if (writes_acc - w0 !== 1) $display("FAIL clean_victim_no_wb: got %0d want 1", writes_acc - w0); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_2800, 4'h0, 32'h0, lat, d);
      ntot++; if (lat !== 1) $display("FAIL plru_keep_2800: got lat %0d want 1", lat); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_2000, 4'h0, 32'h0, lat, d);
      ntot++; if (lat <= 1) $display("FAIL plru_evicted_2000: got lat %0d want >1", lat); else npass++;
   endtask

   task automatic test_flush();
      int lat, w0, r0; logic [31:0] d;
      issue(0, 1, 0, 0, 0, 32'h0000_1804, 4'hF, 32'h55AA55AA, lat, d);
      w0 = writes_acc;
      issue(0, 0, 1, 0, 0, 32'h0000_1800, 4'h0, 32'h0, lat, d);
      ntot++; if (writes_acc - w0 !== 1) $display("FAIL flush_wb_count: got %0d want 1", writes_acc - w0); else npass++;
      ntot++; if (last_wa !== 32'h0000_1800) $display("FAIL flush_wb_addr: got %h want 00001800", last_wa); else npass++;
      ntot++; if (last_wd[63:32] !== 32'h55AA55AA) $display("FAIL flush_wb_word1: got %h want 55aa55aa", last_wd[63:32]); else npass++;
      w0 = writes_acc;
      issue(0, 0, 1, 0, 0, 32'h0000_1800, 4'h0, 32'h0, lat, d);
      ntot++; if (writes_acc !== w0) $display("FAIL reflush_no_wb: got %0d want %0d", writes_acc, w0); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_1804, 4'h0, 32'h0, lat, d);
      ntot++; if (lat !== 1) $display("FAIL flush_keeps_valid: got lat %0d want 1", lat); else npass++;
      ntot++; if (d !== 32'h55AA55AA) $display("FAIL flush_read_data: got %h want 55aa55aa", d); else npass++;
      issue(0, 0, 0, 1, 0, 32'h0000_2800, 4'h0, 32'h0, lat, d);
      ntot++; if (writes_acc !== w0) $display("FAIL invalidate_no_wb: got %0d want %0d", writes_acc, w0); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_2800, 4'h0, 32'h0, lat, d);
      ntot++; if (lat <= 1) $display("FAIL invalidate_then_miss: got lat %0d want >1", lat); else npass++;
      r0 = reads_acc;
      issue(0, 0, 1, 1, 0, 32'h0000_7000, 4'h0, 32'h0, lat, d);
      ntot++; if (lat !== 2) $display("FAIL flush_miss_ready: got lat %0d want 2", lat); else npass++;
      ntot++; if (writes_acc !== w0 || reads_acc !== r0)
         $display("FAIL flush_miss_noop: got w%0d r%0d want w%0d r%0d", writes_acc, reads_acc, w0, r0); else npass++;
   endtask

   task automatic test_flush_all();
      int lat, w0; logic [31:0] d;
      issue(0, 1, 0, 0, 0, 32'h0000_1820, 4'hF, 32'hC0DE0001, lat, d);
      issue(0, 1, 0, 0, 0, 32'h0000_1840, 4'hF, 32'hC0DE0002, lat, d);
      issue(0, 1, 0, 0, 0, 32'h0000_1860, 4'hF, 32'hC0DE0003, lat, d);
      w0 = writes_acc;
      stall = 5;
      issue(0, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, lat, d);
      stall = 0;
      ntot++; if (writes_acc - w0 !== 3) $display("FAIL flush_all_wb_count: got %0d want 3", writes_acc - w0); else npass++;
      ntot++; if (lat <= 256) $display("FAIL flush_all_busy: got %0d cycles want >256", lat); else npass++;
      ntot++; if (last_wa !== 32'h0000_1860) $display("FAIL flush_all_last_addr: got %h want 00001860", last_wa); else npass++;
      ntot++; if (last_wd[31:0] !== 32'hC0DE0003) $display("FAIL flush_all_last_data: got %h want c0de0003", last_wd[31:0]); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_1820, 4'h0, 32'h0, lat, d);
      ntot++; if (lat <= 1) $display("FAIL after_walk_miss_1820: got lat %0d want >1", lat); else npass++;
      ntot++; if (d !== 32'h1820A500) $display("FAIL after_walk_data_1820: got %h want 1820a500", d); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_1804, 4'h0, 32'h0, lat, d);
      ntot++; if (lat <= 1 || d !== 32'h1800A501)
         $display("FAIL after_walk_1804: got lat %0d data %h want >1 and 1800a501", lat, d); else npass++;
      issue(1, 0, 0, 0, 0, 32'h0000_2000, 4'h0, 32'h0, lat, d);
      ntot++; if (lat <= 1) $display("FAIL after_walk_miss_2000: got lat %0d want >1", lat); else npass++;
      ntot++; if (both_err !== 1'b0) $display("FAIL mm_read_write_overlap: got %b want 0", both_err); else npass++;
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_write_hit();
      test_evict();
      test_flush();
      test_flush_all();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
